// File: rtl/intdiv_mulrec_if.sv
// Handshake and operand/result bundle between the divider-result producer
// and the z*y+r reconstructor.
interface intdiv_mulrec_if #(
    parameter int N = 9
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   z;
    logic [N-1:0]   y;
    logic [N-1:0]   r;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] x_rec;
    logic           fits;
    logic           rem_ok;

    modport master (
        output in_valid, z, y, r, out_ready,
        input  in_ready, out_valid, x_rec, fits, rem_ok
    );

    modport slave (
        input  in_valid, z, y, r, out_ready,
        output in_ready, out_valid, x_rec, fits, rem_ok
    );
endinterface

// File: rtl/intdiv_mulrec.sv
// Sequential reconstructor x_rec = z*y + r: radix-2 Booth multiply (N cycles),
// one addend cycle, then a held result with a remainder-consistency flag.
module intdiv_mulrec #(
    parameter int N  = 9,
    parameter int CW = 4
) (
    input  logic clock,
    input  logic reset,
    intdiv_mulrec_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] ADD  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic [N:0]     acc;
    logic [N-1:0]   zq;
    logic           qm1;
    logic [N-1:0]   yl;
    logic [N-1:0]   rl;
    logic [2*N-1:0] x_rec_q;
    logic           fits_q;
    logic           rem_ok_q;
    logic           out_valid_q;

    logic [N:0]     y_ext;
    logic [N:0]     r_ext;
    logic [N:0]     y_abs;
    logic [N:0]     r_abs;
    logic [N:0]     booth_sum;
    logic [2*N-1:0] product;
    logic [2*N-1:0] sum;
    logic           fits_c;
    logic           rem_ok_c;

    always_comb begin
        y_ext = {yl[N-1], yl};
        r_ext = {rl[N-1], rl};
        y_abs = y_ext[N] ? -y_ext : y_ext;
        r_abs = r_ext[N] ? -r_ext : r_ext;
        case ({zq[0], qm1})
            2'b01:   booth_sum = acc + y_ext;
            2'b10:   booth_sum = acc - y_ext;
            default: booth_sum = acc;
        endcase
        // After N shifts the low multiplier bits have been replaced by the
        // low product bits; acc[N] is only a guard bit and never needed here.
        product  = {acc[N-1:0], zq};
        sum      = product + {{N{rl[N-1]}}, rl};
        fits_c   = (&sum[2*N-1:N-1]) | ~(|sum[2*N-1:N-1]);
        rem_ok_c = (|yl) && (r_abs < y_abs) &&
                   (~(|rl) || (rl[N-1] == sum[2*N-1]));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            zq          <= '0;
            qm1         <= 1'b0;
            yl          <= '0;
            rl          <= '0;
            x_rec_q     <= '0;
            fits_q      <= 1'b0;
            rem_ok_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        zq    <= bus.z;
                        yl    <= bus.y;
                        rl    <= bus.r;
                        acc   <= '0;
                        qm1   <= 1'b0;
                        cnt   <= '0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc <= {booth_sum[N], booth_sum[N:1]};
                    zq  <= {booth_sum[0], zq[N-1:1]};
                    qm1 <= zq[0];
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) state <= ADD;
                end
                ADD: begin
                    x_rec_q     <= sum;
                    fits_q      <= fits_c;
                    rem_ok_q    <= rem_ok_c;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                default: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.x_rec     = x_rec_q;
    assign bus.fits      = fits_q;
    assign bus.rem_ok    = rem_ok_q;
endmodule

// File: tb/tb_intdiv_mulrec.sv
// Bench for intdiv_mulrec: directed vector table, randomized ops against an
// arithmetic reference, plus backpressure and mid-operation reset sequences.
module tb_intdiv_mulrec;
    localparam int N  = 9;
    localparam int CW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    intdiv_mulrec_if #(.N(N)) bus ();

    intdiv_mulrec #(.N(N), .CW(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        int     z;
        int     y;
        int     r;
        longint x;
        bit     f;
        bit     ro;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the specification's rules.
    task automatic ref_op(input int zv, input int yv, input int rv,
                          output longint x, output bit f, output bit ro);
        int ar, ay;
        x  = longint'(zv) * longint'(yv) + longint'(rv);
        f  = (x >= -(1 <<< (N - 1))) && (x <= (1 <<< (N - 1)) - 1);
        ar = (rv < 0) ? -rv : rv;
        ay = (yv < 0) ? -yv : yv;
        ro = (yv != 0) && (ar < ay) && ((rv == 0) || ((rv < 0) == (x < 0)));
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(0, (1 << N) - 1)) - (1 << (N - 1));
    endfunction

    task automatic drive_ops(input int zv, input int yv, input int rv);
        logic [31:0] t;
        t = zv; bus.z = t[N-1:0];
        t = yv; bus.y = t[N-1:0];
        t = rv; bus.r = t[N-1:0];
    endtask

    // Accept, wait for result (counting edges including the accept edge),
    // then consume. Inputs may be scrambled while the op is in flight.
    task automatic do_op(input int zv, input int yv, input int rv, input bit scramble,
                         output longint x, output bit f, output bit ro, output int lat);
        int w;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clock); #1; w++;
        end
        if (!bus.in_ready) check("in_ready_before_accept", 0, 1);
        drive_ops(zv, yv, rv);
        bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            if (scramble) drive_ops(rnd_s(), rnd_s(), rnd_s());
            @(posedge clock); #1;
            lat++;
        end
        x  = longint'($signed(bus.x_rec));
        f  = bus.fits;
        ro = bus.rem_ok;
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        check("out_valid_after_consume", longint'(bus.out_valid), 0);
        check("in_ready_after_consume", longint'(bus.in_ready), 1);
    endtask

    initial begin
        vec_t   vecs[$];
        longint x, ex, hx;
        bit     f, ro, ef, ero, hf, hro;
        int     lat, zv, yv, rv;

        vecs.push_back('{2, 3, 1, 7, 1'b1, 1'b1});
        vecs.push_back('{-3, 4, -1, -13, 1'b1, 1'b1});
        vecs.push_back('{-3, 4, 1, -11, 1'b1, 1'b0});
        vecs.push_back('{-256, -256, 0, 65536, 1'b0, 1'b1});
        vecs.push_back('{255, -256, 0, -65280, 1'b0, 1'b1});
        vecs.push_back('{7, 0, 5, 5, 1'b1, 1'b0});
        vecs.push_back('{1, 3, 5, 8, 1'b1, 1'b0});
        vecs.push_back('{0, -256, -255, -255, 1'b1, 1'b1});
        vecs.push_back('{-1, -256, 1, 257, 1'b0, 1'b1});
        vecs.push_back('{-128, 2, -1, -257, 1'b0, 1'b1});
        vecs.push_back('{255, 1, 0, 255, 1'b1, 1'b1});
        vecs.push_back('{-256, 1, 0, -256, 1'b1, 1'b1});

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_ops(0, 0, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_in_ready", longint'(bus.in_ready), 1);
        check("reset_out_valid", longint'(bus.out_valid), 0);
        check("reset_x_rec", longint'($signed(bus.x_rec)), 0);
        check("reset_fits", longint'(bus.fits), 0);
        check("reset_rem_ok", longint'(bus.rem_ok), 0);

        foreach (vecs[i]) begin
            do_op(vecs[i].z, vecs[i].y, vecs[i].r, 1'b1, x, f, ro, lat);
            check("vec_latency", lat, N + 2);
            check($sformatf("vec%0d_x_rec", i), x, vecs[i].x);
            check($sformatf("vec%0d_fits", i), longint'(f), longint'(vecs[i].f));
            check($sformatf("vec%0d_rem_ok", i), longint'(ro), longint'(vecs[i].ro));
        end

        for (int i = 0; i < 40; i++) begin
            zv = rnd_s();
            yv = rnd_s();
            if (i % 2 == 0) begin
                rv = (yv == 0) ? 0 : int'($urandom_range(0, 2 * ((yv < 0) ? -yv : yv) - 2))
                     - (((yv < 0) ? -yv : yv) - 1);
            end else begin
                rv = rnd_s();
            end
            if (i == 5) yv = 0;
            ref_op(zv, yv, rv, ex, ef, ero);
            do_op(zv, yv, rv, 1'b1, x, f, ro, lat);
            check("rand_latency", lat, N + 2);
            check("rand_x_rec", x, ex);
            check("rand_fits", longint'(f), longint'(ef));
            check("rand_rem_ok", longint'(ro), longint'(ero));
        end

        // Backpressure: result must hold while out_ready stays low.
        ref_op(-3, 4, -1, ex, ef, ero);
        drive_ops(-3, 4, -1);
        bus.in_valid = 1'b1;
        @(posedge clock); #1;
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            @(posedge clock); #1; lat++;
        end
        check("bp_latency", lat, N + 2);
        check("bp_x_rec", longint'($signed(bus.x_rec)), ex);
        hx = longint'($signed(bus.x_rec));
        hf = bus.fits;
        hro = bus.rem_ok;
        for (int c = 0; c < 6; c++) begin
            drive_ops(rnd_s(), rnd_s(), rnd_s());
            @(posedge clock); #1;
            check("bp_out_valid", longint'(bus.out_valid), 1);
            check("bp_in_ready", longint'(bus.in_ready), 0);
            check("bp_x_hold", longint'($signed(bus.x_rec)), hx);
            check("bp_fits_hold", longint'(bus.fits), longint'(hf));
            check("bp_rem_ok_hold", longint'(bus.rem_ok), longint'(hro));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        check("bp_release_out_valid", longint'(bus.out_valid), 0);
        check("bp_release_in_ready", longint'(bus.in_ready), 1);

        // Reset during the 4th MUL cycle drops the operation.
        drive_ops(100, -77, 3);
        bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mrst_in_ready", longint'(bus.in_ready), 1);
        check("mrst_out_valid", longint'(bus.out_valid), 0);
        check("mrst_x_rec", longint'($signed(bus.x_rec)), 0);
        check("mrst_fits", longint'(bus.fits), 0);
        check("mrst_rem_ok", longint'(bus.rem_ok), 0);
        repeat (N + 4) begin
            @(posedge clock); #1;
            check("mrst_no_output", longint'(bus.out_valid), 0);
        end
        do_op(5, 5, 0, 1'b0, x, f, ro, lat);
        check("mrst_fresh_latency", lat, N + 2);
        check("mrst_fresh_x_rec", x, 25);
        check("mrst_fresh_fits", longint'(f), 1);
        check("mrst_fresh_rem_ok", longint'(ro), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
